// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the FIFO controller slice.
//   FIFO_PTR_DEFAULT   default pointer width (depth = 2**FIFO_PTR)
//   FIFO_WIDTH_DEFAULT default SRAM data width (the data path bypasses the controller)
//   FIFO_CNT_W         occupancy counter width for the default pointer width
//   grant_e            which requester owned the SRAM port on the last granted cycle
package fifo_pkg;

  localparam int FIFO_PTR_DEFAULT   = 4;
  localparam int FIFO_WIDTH_DEFAULT = 8;
  localparam int FIFO_CNT_W         = FIFO_PTR_DEFAULT + 1;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/fifo_rr_arb.sv
// fifo_rr_arb: two-requester round-robin arbiter for the single SRAM port.
//   clk_i      clock, rising edge
//   rst_i      asynchronous reset, active-high; forces both grants low
//   req_wr_i   legal write request
//   req_rd_i   legal read request
//   gnt_wr_o   write grant (combinational)
//   gnt_rd_o   read grant (combinational)
// The grants are mutually exclusive. On contention the requester that did not
// win the previous granted cycle wins; reset leaves "read" as the last winner
// so the first contention goes to the write side.
module fifo_rr_arb
  import fifo_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_wr_i,
  input  logic req_rd_i,
  output logic gnt_wr_o,
  output logic gnt_rd_o
);

  grant_e last_q, last_d;
  logic   win_wr, win_rd;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= GRANT_RD;
    else       last_q <= last_d;
  end

  // Winner selection and next last-grant
  always_comb begin
    win_wr = 1'b0;
    win_rd = 1'b0;
    if (req_wr_i && req_rd_i) begin
      if (last_q == GRANT_RD) win_wr = 1'b1;
      else                    win_rd = 1'b1;
    end else begin
      win_wr = req_wr_i;
      win_rd = req_rd_i;
    end

    last_d = last_q;
    if (win_wr)      last_d = GRANT_WR;
    else if (win_rd) last_d = GRANT_RD;
  end

  // Outputs, silenced while reset is held
  always_comb begin
    gnt_wr_o = win_wr & ~rst_i;
    gnt_rd_o = win_rd & ~rst_i;
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer, flag and port-arbitration controller in front of a
// single-port SRAM FIFO array. Never raises both SRAM enables in one cycle.
//   fifo_clk / fifo_rst       clock (rising edge) / async active-high reset
//   fifo_wr_req / fifo_rd_req client push / pop requests
//   fifo_wren / fifo_rden     SRAM write / read enables (combinational grants)
//   wr_ptr / rd_ptr           registered SRAM write / read addresses
//   fifo_wr_ack / fifo_rd_ack accepted push / pop (equal to the enables)
//   fifo_rd_valid             SRAM read data valid, one cycle after fifo_rden
//   fifo_count                occupancy 0..FIFO_DEPTH
//   fifo_full / fifo_empty    occupancy at depth / zero
//   fifo_afull / fifo_aempty  count >= AFULL_THRESH / count <= AEMPTY_THRESH
//   fifo_overflow             sticky: push requested while full
//   fifo_underflow            sticky: pop requested while empty
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_PTR      = FIFO_PTR_DEFAULT,
  parameter int FIFO_DEPTH    = 2 ** FIFO_PTR_DEFAULT,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                fifo_clk,
  input  logic                fifo_rst,
  input  logic                fifo_wr_req,
  input  logic                fifo_rd_req,
  output logic                fifo_wren,
  output logic                fifo_rden,
  output logic [FIFO_PTR-1:0] wr_ptr,
  output logic [FIFO_PTR-1:0] rd_ptr,
  output logic                fifo_wr_ack,
  output logic                fifo_rd_ack,
  output logic                fifo_rd_valid,
  output logic [FIFO_PTR:0]   fifo_count,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                fifo_afull,
  output logic                fifo_aempty,
  output logic                fifo_overflow,
  output logic                fifo_underflow
);

  localparam int CNT_W = FIFO_PTR + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0]    AEMPTY_C = CNT_W'(AEMPTY_THRESH);
  localparam logic [FIFO_PTR-1:0] PTR_ONE  = FIFO_PTR'(1);

  logic [FIFO_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                rd_valid_q;

  logic wr_ok, rd_ok;
  logic gnt_wr, gnt_rd;

  assign wr_ok = fifo_wr_req & ~full_q;
  assign rd_ok = fifo_rd_req & ~empty_q;

  fifo_rr_arb u_arb (
    .clk_i    (fifo_clk),
    .rst_i    (fifo_rst),
    .req_wr_i (wr_ok),
    .req_rd_i (rd_ok),
    .gnt_wr_o (gnt_wr),
    .gnt_rd_o (gnt_rd)
  );

  // Next state. Grants are exclusive, so count moves by at most one and
  // the legality gating keeps it inside 0..FIFO_DEPTH. Flags are computed
  // from count_d so they line up with the registered count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (gnt_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + 1'b1;
    end else if (gnt_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q - 1'b1;
    end
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    ovf_d    = ovf_q | (fifo_wr_req & full_q);
    unf_d    = unf_q | (fifo_rd_req & empty_q);
  end

  always_ff @(posedge fifo_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= gnt_rd;
    end
  end

  assign fifo_wren      = gnt_wr;
  assign fifo_rden      = gnt_rd;
  assign fifo_wr_ack    = gnt_wr;
  assign fifo_rd_ack    = gnt_rd;
  assign wr_ptr         = wr_ptr_q;
  assign rd_ptr         = rd_ptr_q;
  assign fifo_count     = count_q;
  assign fifo_full      = full_q;
  assign fifo_empty     = empty_q;
  assign fifo_afull     = afull_q;
  assign fifo_aempty    = aempty_q;
  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = unf_q;
  assign fifo_rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: self-checking bench for sync_fifo_ctrl. A behavioural
// SRAM sits on the DUT's pointers/enables; written words are queued and
// compared in order whenever fifo_rd_valid is high.
module tb_sync_fifo_ctrl;

  logic       fifo_clk = 1'b0;
  logic       fifo_rst = 1'b1;
  logic       fifo_wr_req = 1'b0;
  logic       fifo_rd_req = 1'b0;
  logic       fifo_wren, fifo_rden, fifo_wr_ack, fifo_rd_ack, fifo_rd_valid;
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] fifo_count;
  logic       fifo_full, fifo_empty, fifo_afull, fifo_aempty;
  logic       fifo_overflow, fifo_underflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [16];
  logic [7:0] rdata;
  logic [7:0] wdata = 8'h00;
  logic [7:0] exp_q [$];

  always #5 fifo_clk = ~fifo_clk;

  sync_fifo_ctrl #(
    .FIFO_PTR      (4),
    .FIFO_DEPTH    (16),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) dut (
    .fifo_clk       (fifo_clk),
    .fifo_rst       (fifo_rst),
    .fifo_wr_req    (fifo_wr_req),
    .fifo_rd_req    (fifo_rd_req),
    .fifo_wren      (fifo_wren),
    .fifo_rden      (fifo_rden),
    .wr_ptr         (wr_ptr),
    .rd_ptr         (rd_ptr),
    .fifo_wr_ack    (fifo_wr_ack),
    .fifo_rd_ack    (fifo_rd_ack),
    .fifo_rd_valid  (fifo_rd_valid),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_afull     (fifo_afull),
    .fifo_aempty    (fifo_aempty),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // SRAM model plus scoreboard push side
  always @(posedge fifo_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      exp_q.delete();
    end else begin
      if (fifo_wren) begin
        mem[wr_ptr] = wdata;
        exp_q.push_back(wdata);
        wdata = wdata + 8'd1;
      end
      if (fifo_rden) rdata = mem[rd_ptr];
    end
  end

  // Scoreboard pop side
  always @(negedge fifo_clk) begin
    if (fifo_rd_valid) begin
      if (exp_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
      else check("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
    end
  end

  // One cycle: drive requests just after the edge, sample grants mid-cycle,
  // then advance past the next edge.
  task automatic step(input logic wr, input logic rd, output logic gw, output logic gr);
    fifo_wr_req = wr;
    fifo_rd_req = rd;
    #1;
    gw = fifo_wren;
    gr = fifo_rden;
    check("excl", {31'd0, fifo_wren & fifo_rden}, 32'd0);
    check("acks", {30'd0, fifo_wr_ack, fifo_rd_ack}, {30'd0, fifo_wren, fifo_rden});
    @(posedge fifo_clk);
    #1;
    fifo_wr_req = 1'b0;
    fifo_rd_req = 1'b0;
  endtask

  task automatic do_reset();
    fifo_rst    = 1'b1;
    fifo_wr_req = 1'b1;
    fifo_rd_req = 1'b1;
    #1;
    check("rst_en", {28'd0, fifo_wren, fifo_rden, fifo_wr_ack, fifo_rd_ack}, 32'd0);
    @(posedge fifo_clk);
    @(posedge fifo_clk);
    #1;
    fifo_wr_req = 1'b0;
    fifo_rd_req = 1'b0;
    fifo_rst    = 1'b0;
  endtask

  task automatic fill(input int n);
    logic gw, gr;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, gw, gr);
      check("fill_gnt", {31'd0, gw}, 32'd1);
    end
  endtask

  initial begin
    logic gw, gr;
    int   pushes, pops;

    // Reset state
    do_reset();
    check("rst_flags", {26'd0, fifo_empty, fifo_aempty, fifo_full, fifo_afull,
                        fifo_overflow, fifo_underflow}, 32'b110000);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_ptrs", {24'd0, wr_ptr, rd_ptr}, 32'd0);
    check("rst_rdv", {31'd0, fifo_rd_valid}, 32'd0);

    // Async reset mid-fill drops contents immediately
    fill(5);
    check("pre_rst_count", {27'd0, fifo_count}, 32'd5);
    #2 fifo_rst = 1'b1;
    #1;
    check("async_count", {27'd0, fifo_count}, 32'd0);
    check("async_empty", {31'd0, fifo_empty}, 32'd1);
    do_reset();

    // 16 pushes, flags along the way, wrap and overflow
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, gw, gr);
      check("push_gnt", {31'd0, gw}, 32'd1);
      check("push_count", {27'd0, fifo_count}, i);
      check("push_afull", {31'd0, fifo_afull}, (i >= 14) ? 32'd1 : 32'd0);
      check("push_full", {31'd0, fifo_full}, (i == 16) ? 32'd1 : 32'd0);
      check("push_aempty", {31'd0, fifo_aempty}, (i <= 2) ? 32'd1 : 32'd0);
    end
    check("wr_wrap", {28'd0, wr_ptr}, 32'd0);
    step(1'b1, 1'b0, gw, gr);
    check("ovf_gnt", {31'd0, gw}, 32'd0);
    check("ovf_flag", {31'd0, fifo_overflow}, 32'd1);
    check("ovf_count", {27'd0, fifo_count}, 32'd16);
    check("ovf_wrptr", {28'd0, wr_ptr}, 32'd0);

    // Full with both requests: read wins, then round-robin gives write
    step(1'b1, 1'b1, gw, gr);
    check("full_both", {30'd0, gw, gr}, 32'b01);
    check("full_both_cnt", {27'd0, fifo_count}, 32'd15);
    step(1'b1, 1'b1, gw, gr);
    check("rr_both", {30'd0, gw, gr}, 32'b10);
    check("rr_both_cnt", {27'd0, fifo_count}, 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, gw, gr);
    step(1'b0, 1'b0, gw, gr);
    check("drain_empty", {31'd0, fifo_empty}, 32'd1);
    check("drain_sb", exp_q.size(), 32'd0);

    // Three pushes, three pops, rd_valid timing, underflow
    do_reset();
    fill(3);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, gw, gr);
      check("pop_gnt", {31'd0, gr}, 32'd1);
      check("pop_rdv", {31'd0, fifo_rd_valid}, 32'd1);
      check("pop_rdptr", {28'd0, rd_ptr}, i);
    end
    check("pop_empty", {31'd0, fifo_empty}, 32'd1);
    step(1'b0, 1'b1, gw, gr);
    check("unf_gnt", {31'd0, gr}, 32'd0);
    check("unf_rdv", {31'd0, fifo_rd_valid}, 32'd0);
    check("unf_flag", {31'd0, fifo_underflow}, 32'd1);
    check("unf_rdptr", {28'd0, rd_ptr}, 32'd3);
    check("unf_ovf", {31'd0, fifo_overflow}, 32'd0);

    // Contention at count 4 with last winner = read: W,R,W,R
    do_reset();
    fill(5);
    step(1'b0, 1'b1, gw, gr);
    check("cont_pre", {27'd0, fifo_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, gw, gr);
      check("cont_gnt", {30'd0, gw, gr}, (i % 2 == 0) ? 32'b10 : 32'b01);
    end
    check("cont_count", {27'd0, fifo_count}, 32'd4);

    // Wrap stress: 40 push/pop pairs with random idle gaps
    do_reset();
    fill(5);
    pushes = 5;
    pops   = 0;
    for (int i = 0; i < 40; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b0, 1'b0, gw, gr);
      step(1'b1, 1'b0, gw, gr);
      if (gw !== 1'b1) check("ws_push", {31'd0, gw}, 32'd1);
      pushes++;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1'b0, 1'b0, gw, gr);
      step(1'b0, 1'b1, gw, gr);
      if (gr !== 1'b1) check("ws_pop", {31'd0, gr}, 32'd1);
      pops++;
    end
    check("ws_count", {27'd0, fifo_count}, pushes - pops);
    check("ws_wrptr", {28'd0, wr_ptr}, pushes % 16);
    check("ws_rdptr", {28'd0, rd_ptr}, pops % 16);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, gw, gr);
    step(1'b0, 1'b0, gw, gr);
    check("ws_empty", {31'd0, fifo_empty}, 32'd1);
    check("ws_sb", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
